// File: rtl/fa_mux_pkg.sv
// fa_mux_pkg: shared constants and a behavioural reference for the
// mux-built ripple-carry adder fa_mux.
//   FA_MUX_MAX_WIDTH : largest supported operand width
//   fa_mux_ref       : returns {cout, sum} of a + b + cin at full 64-bit width;
//                      bit WIDTH of the result is the carry-out for a
//                      WIDTH-bit adder whose operands are zero-extended.
package fa_mux_pkg;

  localparam int FA_MUX_MAX_WIDTH = 64;

  function automatic logic [64:0] fa_mux_ref(input logic [63:0] a,
                                             input logic [63:0] b,
                                             input logic        cin);
    return {1'b0, a} + {1'b0, b} + {64'd0, cin};
  endfunction

endpackage

// File: rtl/fa_mux_mux2.sv
// mux2: 1-bit 2:1 multiplexer, the only logic cell used by the fa_mux
// datapath.
//   sel : select, 0 picks d0, 1 picks d1
//   d0  : data input selected when sel=0
//   d1  : data input selected when sel=1
//   y   : selected output
module mux2 (
  input  logic sel,
  input  logic d0,
  input  logic d1,
  output logic y
);

  assign y = sel ? d1 : d0;

endmodule

// File: rtl/fa_mux.sv
// fa_mux: WIDTH-bit ripple-carry adder whose full-adder slices are built
// purely from mux2 cells; sum and carry-out are registered once (1-cycle
// latency, one result per clock, no backpressure).
//   clk       : rising-edge clock
//   rst       : asynchronous active-high reset
//   in_valid  : a/b/cin valid this cycle
//   a, b      : WIDTH-bit operands
//   cin       : carry-in to bit 0
//   sum       : registered sum
//   cout      : registered carry-out of the MSB
//   out_valid : sum/cout hold a fresh result
//   ovf       : registered two's-complement overflow (only when the macro
//               FA_MUX_OVF_EN is defined)
module fa_mux
  import fa_mux_pkg::*;
#(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             out_valid
`ifdef FA_MUX_OVF_EN
  ,
  output logic             ovf
`endif
);

  if (WIDTH < 1 || WIDTH > FA_MUX_MAX_WIDTH) begin : g_bad_width
    $error("fa_mux: WIDTH out of range 1..64");
  end

  logic [WIDTH:0]   c;   // ripple carry chain, c[0] = cin
  logic [WIDTH-1:0] nc;  // ~c[i], also reused by the overflow mux
  logic [WIDTH-1:0] p;   // b ^ c
  logic [WIDTH-1:0] np;  // ~p
  logic [WIDTH-1:0] nb;  // ~b
  logic [WIDTH-1:0] t;   // a ^ b (carry propagate)
  logic [WIDTH-1:0] s;   // combinational sum

  assign c[0] = cin;

  // Each inversion is a mux2 with constant data inputs, so the whole slice
  // is mux-only. Carry: when a==b the carry equals a (both 0 or both 1);
  // otherwise the incoming carry propagates.
  for (genvar i = 0; i < WIDTH; i++) begin : g_slice
    mux2 u_nc  (.sel(c[i]), .d0(1'b1),  .d1(1'b0),  .y(nc[i]));
    mux2 u_p   (.sel(b[i]), .d0(c[i]),  .d1(nc[i]), .y(p[i]));
    mux2 u_np  (.sel(p[i]), .d0(1'b1),  .d1(1'b0),  .y(np[i]));
    mux2 u_sum (.sel(a[i]), .d0(p[i]),  .d1(np[i]), .y(s[i]));
    mux2 u_nb  (.sel(b[i]), .d0(1'b1),  .d1(1'b0),  .y(nb[i]));
    mux2 u_t   (.sel(a[i]), .d0(b[i]),  .d1(nb[i]), .y(t[i]));
    mux2 u_c   (.sel(t[i]), .d0(a[i]),  .d1(c[i]),  .y(c[i+1]));
  end

`ifdef FA_MUX_OVF_EN
  logic ovf_d;

  // Signed overflow is c[WIDTH] ^ c[WIDTH-1].
  mux2 u_ovf (.sel(c[WIDTH]), .d0(c[WIDTH-1]), .d1(nc[WIDTH-1]), .y(ovf_d));
`endif

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values; all output registers are reset because
  // out_valid and the held sum are architecturally visible.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sum       <= '0;
      cout      <= 1'b0;
      out_valid <= 1'b0;
`ifdef FA_MUX_OVF_EN
      ovf       <= 1'b0;
`endif
    end else begin
      out_valid <= in_valid;
      if (in_valid) begin
        sum  <= s;
        cout <= c[WIDTH];
`ifdef FA_MUX_OVF_EN
        ovf  <= ovf_d;
`endif
      end
    end
  end

endmodule

// File: tb/tb_fa_mux.sv
// tb_fa_mux: directed self-checking bench for fa_mux. Instantiates a
// WIDTH=1 and a WIDTH=8 copy on a shared clock and reset. Inputs change
// 1 ns after the rising edge; outputs are checked 1 ns after the next edge.
// Overflow checks are compiled in when FA_MUX_OVF_EN is defined.
module tb_fa_mux;
  import fa_mux_pkg::*;

  logic       clk = 1'b0;
  logic       rst = 1'b0;

  logic       iv1 = 1'b0;
  logic [0:0] a1  = '0;
  logic [0:0] b1  = '0;
  logic       cin1 = 1'b0;
  logic [0:0] sum1;
  logic       cout1;
  logic       ov1;

  logic       iv8 = 1'b0;
  logic [7:0] a8  = '0;
  logic [7:0] b8  = '0;
  logic       cin8 = 1'b0;
  logic [7:0] sum8;
  logic       cout8;
  logic       ov8;
`ifdef FA_MUX_OVF_EN
  logic       ovf1;
  logic       ovf8;
`endif

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  fa_mux #(.WIDTH(1)) u_dut1 (
    .clk(clk), .rst(rst), .in_valid(iv1), .a(a1), .b(b1), .cin(cin1),
    .sum(sum1), .cout(cout1), .out_valid(ov1)
`ifdef FA_MUX_OVF_EN
    , .ovf(ovf1)
`endif
  );

  fa_mux #(.WIDTH(8)) u_dut8 (
    .clk(clk), .rst(rst), .in_valid(iv8), .a(a8), .b(b8), .cin(cin8),
    .sum(sum8), .cout(cout8), .out_valid(ov8)
`ifdef FA_MUX_OVF_EN
    , .ovf(ovf8)
`endif
  );

  task automatic check(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive8(input logic [7:0] a, input logic [7:0] b,
                        input logic c);
    a8 = a; b8 = b; cin8 = c; iv8 = 1'b1;
  endtask

  task automatic expect8(input string tag, input logic [7:0] s,
                         input logic co);
    check({tag, ".sum"},  64'(sum8),  64'(s));
    check({tag, ".cout"}, 64'(cout8), 64'(co));
    check({tag, ".ov"},   64'(ov8),   64'd1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [1:0]  exp1 [8];
    logic [64:0] r;
    logic [7:0]  ra, rb;
    logic        rc;

    exp1 = '{2'b00, 2'b01, 2'b01, 2'b10, 2'b01, 2'b10, 2'b10, 2'b11};

    // Reset is asynchronous: outputs clear before any clock edge.
    #1 rst = 1'b1;
    #2;
    check("rst.sum1",  64'(sum1),  64'd0);
    check("rst.cout1", 64'(cout1), 64'd0);
    check("rst.ov1",   64'(ov1),   64'd0);
    check("rst.sum8",  64'(sum8),  64'd0);
    check("rst.cout8", 64'(cout8), 64'd0);
    check("rst.ov8",   64'(ov8),   64'd0);
    tick();
    tick();
    rst = 1'b0;

    // WIDTH=1: exhaustive truth table, one operand set per cycle.
    for (int i = 0; i < 8; i++) begin
      {a1, b1, cin1} = 3'(i);
      iv1 = 1'b1;
      tick();
      check($sformatf("w1.%0d.cs", i), 64'({cout1, sum1}), 64'(exp1[i]));
      check($sformatf("w1.%0d.ov", i), 64'(ov1), 64'd1);
    end
    iv1 = 1'b0;
    {a1, b1, cin1} = 3'b000;
    tick();
    check("w1.idle.ov",   64'(ov1),            64'd0);
    check("w1.idle.hold", 64'({cout1, sum1}), 64'b11);

    // WIDTH=8 boundaries.
    drive8(8'hFF, 8'h01, 1'b0); tick(); expect8("w8.ff_01", 8'h00, 1'b1);
    drive8(8'hFF, 8'hFF, 1'b1); tick(); expect8("w8.ff_ff_1", 8'hFF, 1'b1);
    drive8(8'h00, 8'h00, 1'b0); tick(); expect8("w8.zero", 8'h00, 1'b0);

    // Back-to-back results on consecutive cycles.
    drive8(8'h12, 8'h34, 1'b0); tick(); expect8("w8.b2b0", 8'h46, 1'b0);
    drive8(8'h80, 8'h80, 1'b1); tick(); expect8("w8.b2b1", 8'h01, 1'b1);

    // A few more operand patterns checked against the package reference.
    for (int i = 0; i < 6; i++) begin
      ra = 8'($urandom); rb = 8'($urandom); rc = 1'($urandom);
      r  = fa_mux_ref({56'd0, ra}, {56'd0, rb}, rc);
      drive8(ra, rb, rc);
      tick();
      expect8($sformatf("w8.rnd%0d", i), r[7:0], r[8]);
    end

    // Asynchronous reset between edges while a result is held.
    drive8(8'h12, 8'h34, 1'b0); tick();
    check("mid.pre.ov", 64'(ov8), 64'd1);
    #2 rst = 1'b1;
    #1;
    check("mid.sum",  64'(sum8),  64'd0);
    check("mid.cout", 64'(cout8), 64'd0);
    check("mid.ov",   64'(ov8),   64'd0);
    iv8 = 1'b0;
    #2 rst = 1'b0;
    tick();
    check("mid.rel.ov",  64'(ov8),  64'd0);
    check("mid.rel.sum", 64'(sum8), 64'd0);

    // Idle cycles: operands wander, X included; result holds, no valid.
    drive8(8'h12, 8'h34, 1'b0); tick(); expect8("idle.load", 8'h46, 1'b0);
    iv8 = 1'b0;
    for (int i = 0; i < 4; i++) begin
      a8 = 8'($urandom); b8 = 8'($urandom); cin8 = 1'($urandom);
      tick();
      check($sformatf("idle%0d.sum", i),  64'(sum8),  64'h46);
      check($sformatf("idle%0d.cout", i), 64'(cout8), 64'd0);
      check($sformatf("idle%0d.ov", i),   64'(ov8),   64'd0);
    end
    a8 = 'x; b8 = 'x; cin8 = 1'bx;
    tick();
    check("idle.x.ov",  64'(ov8),  64'd0);
    check("idle.x.sum", 64'(sum8), 64'h46);

`ifdef FA_MUX_OVF_EN
    drive8(8'h7F, 8'h01, 1'b0); tick();
    expect8("ovf.7f_01", 8'h80, 1'b0);
    check("ovf.7f_01.ovf", 64'(ovf8), 64'd1);
    iv8 = 1'b0;
    tick();
    check("ovf.hold", 64'(ovf8), 64'd1);
    drive8(8'hFF, 8'h01, 1'b0); tick();
    expect8("ovf.ff_01", 8'h00, 1'b1);
    check("ovf.ff_01.ovf", 64'(ovf8), 64'd0);
`endif

    iv8 = 1'b0;
    tick();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
